// File: rtl/fft_pkg.sv
// Shared constants, complex word type and bit-reversal helper for the 4-lane
// N=128 FFT output stage.
package fft_pkg;

    localparam int NBITS_out = 15;
    localparam int N         = 128;
    localparam int LOG2N     = 7;
    localparam int NBEATS    = N / 4;
    localparam int CNT_W     = LOG2N - 2;

    typedef struct packed {
        logic signed [NBITS_out-1:0] re;
        logic signed [NBITS_out-1:0] im;
    } cplx_t;

    typedef logic [LOG2N-1:0] addr_t;

    // Write-side mode: storing the current frame, or discarding it because
    // its target bank was still occupied when the frame started.
    typedef enum logic {
        WR_STORE = 1'b0,
        WR_DROP  = 1'b1
    } wr_mode_t;

    function automatic addr_t bitrev(input addr_t a);
        addr_t r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Natural-order output stream of the reorder stage: four bins per beat over
// valid/ready, plus a frame-start marker.
interface fft_out_reorder_if;
    import fft_pkg::*;

    logic  o_valid;
    logic  i_ready;
    logic  o_frame_start;
    cplx_t o_bin0;
    cplx_t o_bin1;
    cplx_t o_bin2;
    cplx_t o_bin3;

    modport master (
        output o_valid, o_frame_start, o_bin0, o_bin1, o_bin2, o_bin3,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_frame_start, o_bin0, o_bin1, o_bin2, o_bin3,
        output i_ready
    );

endinterface

// File: rtl/fft_reorder_bank.sv
// One N-word register bank with four independent write ports and four
// combinational read ports.
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  addr_t [3:0]      wr_addr,
    input  cplx_t [3:0]      wr_data,
    input  logic  [3:0]      we,
    input  addr_t [3:0]      rd_addr,
    output cplx_t [3:0]      rd_data
);

    cplx_t mem [N];

    // NOTE: the array is cleared on reset because the output bins read it
    // directly and must show zero after reset; a RAM-style bank would skip this.
    // NOTE: sequential state always uses <= so all four lane writes and the
    // reads in the same cycle see the pre-edge contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) mem[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) rd_data[j] = mem[rd_addr[j]];
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Captures bit-reversed 4-lane FFT output into a ping-pong buffer and replays
// each frame in natural bin order; frames arriving into a busy bank are dropped.
module fft_out_reorder
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic [2*NBITS_out-1:0] fftIn0_up,
    input  logic [2*NBITS_out-1:0] fftIn0_down,
    input  logic [2*NBITS_out-1:0] fftIn1_up,
    input  logic [2*NBITS_out-1:0] fftIn1_down,
    fft_out_reorder_if.master      dout,
    output logic                   o_overflow
);

    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic             wr_bank, rd_bank;
    logic [1:0]       full, full_nxt;
    wr_mode_t         wr_mode, wr_mode_nxt;

    logic start_drop, dropping, wr_last, store, rd_fire, rd_last;

    // A frame is judged only at its first beat, against the registered full flag.
    assign start_drop = i_enable && (wr_cnt == '0) && full[wr_bank];
    assign dropping   = (wr_mode == WR_DROP) || start_drop;
    assign wr_last    = i_enable && (wr_cnt == CNT_W'(NBEATS-1));
    assign store      = i_enable && !dropping;
    assign rd_fire    = full[rd_bank] && dout.i_ready;
    assign rd_last    = rd_fire && (rd_cnt == CNT_W'(NBEATS-1));

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_mode_nxt = wr_mode;
        full_nxt    = full;
        case (wr_mode)
            WR_STORE: if (start_drop) wr_mode_nxt = WR_DROP;
            WR_DROP:  if (wr_last)    wr_mode_nxt = WR_STORE;
            default:                  wr_mode_nxt = WR_STORE;
        endcase
        if (store && wr_last) full_nxt[wr_bank] = 1'b1;
        // Write and release never target the same bank, so order is irrelevant.
        if (rd_last)          full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_mode    <= WR_STORE;
            full       <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            wr_mode <= wr_mode_nxt;
            full    <= full_nxt;
            if (i_enable)         wr_cnt  <= wr_last ? '0 : wr_cnt + 1'b1;
            if (store && wr_last) wr_bank <= ~wr_bank;
            if (start_drop)       o_overflow <= 1'b1;
            if (rd_fire)          rd_cnt  <= rd_last ? '0 : rd_cnt + 1'b1;
            if (rd_last)          rd_bank <= ~rd_bank;
        end
    end

    addr_t [3:0] wr_addr, rd_addr;
    cplx_t [3:0] wr_data, rd_data0, rd_data1, rd_sel;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_addr[k] = bitrev({wr_cnt, 2'(k)});
            rd_addr[k] = {rd_cnt, 2'(k)};
        end
        wr_data[0] = fftIn0_up;
        wr_data[1] = fftIn0_down;
        wr_data[2] = fftIn1_up;
        wr_data[3] = fftIn1_down;
    end

    fft_reorder_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .we      ({4{store && !wr_bank}}),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    fft_reorder_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .we      ({4{store && wr_bank}}),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    assign rd_sel             = rd_bank ? rd_data1 : rd_data0;
    assign dout.o_valid       = full[rd_bank];
    assign dout.o_frame_start = full[rd_bank] && (rd_cnt == '0);
    assign dout.o_bin0        = rd_sel[0];
    assign dout.o_bin1        = rd_sel[1];
    assign dout.o_bin2        = rd_sel[2];
    assign dout.o_bin3        = rd_sel[3];

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: scenario table plus hand-written
// latency and asynchronous-reset sequences; data pattern re=bin, im=-bin.
`timescale 1ns/1ps
module tb_fft_out_reorder;
    import fft_pkg::*;

    localparam int W = 2*NBITS_out;
    typedef logic [4*W:0] beat_t;   // {frame_start, bin3, bin2, bin1, bin0}

    typedef struct {
        string name;
        int    nframes;
        bit    gap;
        int    ready_mode;   // 0: always 1, 1: low for 'hold' cycles, 2: toggle 1,0,...
        int    hold;
        int    exp_frames;
        bit    exp_ovf;
        int    exp_valid;    // expected o_valid cycle count, -1 to skip
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_enable = 1'b0;
    logic [W-1:0] in0_up = '0, in0_down = '0, in1_up = '0, in1_down = '0;
    logic         o_overflow;

    fft_out_reorder_if dout_if ();

    fft_out_reorder dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (i_enable),
        .fftIn0_up   (in0_up),
        .fftIn0_down (in0_down),
        .fftIn1_up   (in1_up),
        .fftIn1_down (in1_down),
        .dout        (dout_if.master),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    beat_t rx_q[$];
    int    valid_cycles = 0;
    logic  stall_prev = 1'b0;
    beat_t stall_bins;
    beat_t mon_cur;
    vec_t  vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int tb_bitrev(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < LOG2N; i++) begin
            r = (r << 1) | (x & 1);
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] word(input int bin);
        logic [NBITS_out-1:0] re, im;
        re = NBITS_out'(bin);
        im = NBITS_out'(-bin);
        return {re, im};
    endfunction

    function automatic beat_t exp_beat(input int r);
        return {1'(r == 0), word(4*r+3), word(4*r+2), word(4*r+1), word(4*r)};
    endfunction

    // Monitor: collect transfers, count valid cycles, check hold under stall.
    always @(negedge clk) begin
        if (rst) begin
            mon_cur = {dout_if.o_frame_start, dout_if.o_bin3, dout_if.o_bin2,
                       dout_if.o_bin1, dout_if.o_bin0};
            if (stall_prev && dout_if.o_valid) check("stall_hold", mon_cur, stall_bins);
            stall_prev = dout_if.o_valid && !dout_if.i_ready;
            stall_bins = mon_cur;
            if (dout_if.o_valid) valid_cycles++;
            if (dout_if.o_valid && dout_if.i_ready) rx_q.push_back(mon_cur);
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_beat(input int c);
        in0_up   = word(tb_bitrev(4*c));
        in0_down = word(tb_bitrev(4*c+1));
        in1_up   = word(tb_bitrev(4*c+2));
        in1_down = word(tb_bitrev(4*c+3));
        i_enable = 1'b1;
        @(posedge clk); #1;
        i_enable = 1'b0;
    endtask

    task automatic send_frame(input bit gap);
        for (int c = 0; c < NBEATS; c++) begin
            send_beat(c);
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_enable = 1'b0;
        dout_if.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_q.delete();
        valid_cycles = 0;
        rst = 1'b1;
    endtask

    task automatic check_rx(input string name, input int nframes);
        int n;
        check({name, "_count"}, rx_q.size(), nframes*NBEATS);
        n = (rx_q.size() < nframes*NBEATS) ? rx_q.size() : nframes*NBEATS;
        for (int i = 0; i < n; i++) check({name, "_beat"}, rx_q[i], exp_beat(i % NBEATS));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"single",   1, 1'b0, 0,  0, 1, 1'b0, 32};
        vecs[1] = '{"b2b",      3, 1'b0, 0,  0, 3, 1'b0, 96};
        vecs[2] = '{"backpres", 3, 1'b0, 1, 70, 2, 1'b1, -1};
        vecs[3] = '{"stall",    1, 1'b0, 2,  0, 1, 1'b0, -1};
        vecs[4] = '{"gaps",     1, 1'b1, 0,  0, 1, 1'b0, 32};

        dout_if.i_ready = 1'b0;
        #2;
        check("reset_state",
              {dout_if.o_valid, dout_if.o_frame_start, o_overflow,
               dout_if.o_bin0, dout_if.o_bin1, dout_if.o_bin2, dout_if.o_bin3}, '0);

        // Latency: o_valid rises one cycle after the last input beat.
        do_reset();
        for (int c = 0; c < NBEATS-1; c++) send_beat(c);
        check("pre_last_valid", dout_if.o_valid, 1'b0);
        send_beat(NBEATS-1);
        check("latency_valid", dout_if.o_valid, 1'b1);
        check("latency_fs", dout_if.o_frame_start, 1'b1);
        check("latency_beat0",
              {dout_if.o_frame_start, dout_if.o_bin3, dout_if.o_bin2, dout_if.o_bin1, dout_if.o_bin0},
              exp_beat(0));
        dout_if.i_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_rx("latency", 1);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            fork
                begin
                    for (int f = 0; f < vecs[v].nframes; f++) send_frame(vecs[v].gap);
                end
                begin
                    for (int cyc = 0; cyc < 400; cyc++) begin
                        case (vecs[v].ready_mode)
                            1:       dout_if.i_ready = (cyc >= vecs[v].hold);
                            2:       dout_if.i_ready = (cyc % 2 == 0);
                            default: dout_if.i_ready = 1'b1;
                        endcase
                        @(posedge clk); #1;
                    end
                end
            join
            check_rx(vecs[v].name, vecs[v].exp_frames);
            check({vecs[v].name, "_ovf"}, o_overflow, vecs[v].exp_ovf);
            check({vecs[v].name, "_drained"}, dout_if.o_valid, 1'b0);
            if (vecs[v].exp_valid >= 0)
                check({vecs[v].name, "_valid_cycles"}, valid_cycles, vecs[v].exp_valid);
        end

        // Async reset mid-frame with both banks full and overflow set.
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(1'b0);
        for (int c = 0; c < 10; c++) send_beat(c);
        check("pre_rst_valid", dout_if.o_valid, 1'b1);
        check("pre_rst_ovf", o_overflow, 1'b1);
        check("pre_rst_fs", dout_if.o_frame_start, 1'b1);
        in0_up = word(tb_bitrev(40));
        i_enable = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("async_valid", dout_if.o_valid, 1'b0);
        check("async_ovf", o_overflow, 1'b0);
        check("async_fs", dout_if.o_frame_start, 1'b0);
        i_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_q.delete();
        valid_cycles = 0;
        rst = 1'b1;
        dout_if.i_ready = 1'b1;
        send_frame(1'b0);
        repeat (40) @(posedge clk);
        #1;
        check_rx("post_rst", 1);
        check("post_rst_ovf", o_overflow, 1'b0);
        check("post_rst_valid_cycles", valid_cycles, NBEATS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
